xif_sqrt_csr: RTL and testbench

XIF_SQRT_CSR -- requirements
Module: xif_sqrt_csr

---
 rtl/xif_sqrt_pkg.sv | 31 +++
 rtl/sqrt_iter.sv | 101 ++++++++++
 rtl/xif_sqrt_csr.sv | 180 ++++++++++++++++++
 tb/tb_xif_sqrt_csr.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_sqrt_pkg.sv
// -----------------------------------------------------------------------------
// xif_sqrt_pkg
// Shared constants and types for the memory-mapped integer square-root block:
// register offsets inside the 16-byte window, STATUS bit positions, the number
// of digit iterations and the two-state sequencer enum.
// No ports (package).
// -----------------------------------------------------------------------------
package xif_sqrt_pkg;

   // Byte offsets of the four registers inside the window
   localparam logic [3:0] OFF_X      = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_ROOT   = 4'h8;
   localparam logic [3:0] OFF_REM    = 4'hC;

   // Bit positions inside STATUS
   localparam int BIT_BUSY = 0;
   localparam int BIT_DONE = 1;
   localparam int BIT_ERR  = 2;
   localparam int BIT_IE   = 8;

   // One root bit per iteration, 32-bit radicand -> 16 root bits
   localparam int ITERATIONS = 16;
   localparam int CNT_W      = $clog2(ITERATIONS);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } sqrt_state_t;

endpackage

// File: rtl/sqrt_iter.sv
// -----------------------------------------------------------------------------
// sqrt_iter
// Restoring digit-by-digit integer square root. A start pulse in IDLE captures
// the radicand; the block then spends exactly ITERATIONS cycles in CALC,
// producing one root bit per cycle, most significant first.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   start         : begin a computation (honoured only when idle)
//   radicand      : 32-bit unsigned value to take the root of
//   busy          : high while a computation is in progress
//   done          : high in the last CALC cycle; root/rem are valid then
//   root          : 16-bit floor(sqrt(radicand)), valid with done
//   rem           : 17-bit radicand - root*root, valid with done
// -----------------------------------------------------------------------------
module sqrt_iter
   import xif_sqrt_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start,
   input  logic [31:0] radicand,
   output logic        busy,
   output logic        done,
   output logic [15:0] root,
   output logic [16:0] rem
);

   sqrt_state_t      state;
   logic [CNT_W-1:0] iterCount;
   logic [31:0]      radShift;
   logic [17:0]      remReg;
   logic [15:0]      rootReg;

   logic [19:0]      remShifted;
   logic [19:0]      trialValue;
   logic             trialFits;
   logic [17:0]      remNext;
   logic [15:0]      rootNext;

   // One restoring step: bring down the next two radicand bits, try to
   // subtract 4*root+1, and keep the subtraction only if it does not go
   // negative. The result bit is 1 exactly when the subtraction is kept.
   // Widened to 20 bits so the compare never wraps; the kept remainder
   // always fits in 18 bits.
   always_comb begin
      remShifted = {remReg, radShift[31:30]};
      trialValue = {2'b00, rootReg, 2'b01};
      trialFits  = (remShifted >= trialValue);
      remNext    = remShifted[17:0];
      rootNext   = {rootReg[14:0], 1'b0};
      if (trialFits) begin
         remNext  = 18'(remShifted - trialValue);
         rootNext = {rootReg[14:0], 1'b1};
      end
   end

   // Sequencer and datapath registers. Starting clears the partial root and
   // remainder so nothing from a previous or aborted run leaks in; reset
   // simply drops back to IDLE, so an interrupted run never reports done.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         iterCount <= '0;
         radShift  <= '0;
         remReg    <= '0;
         rootReg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= CALC;
                  iterCount <= '0;
                  radShift  <= radicand;
                  remReg    <= '0;
                  rootReg   <= '0;
               end
            end
            CALC: begin
               radShift  <= {radShift[29:0], 2'b00};
               remReg    <= remNext;
               rootReg   <= rootNext;
               iterCount <= iterCount + 1'b1;
               if (iterCount == CNT_W'(ITERATIONS - 1)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The final step's result is handed out combinationally so the register
   // file can capture it on the same edge that ends the last CALC cycle.
   always_comb begin
      busy = (state == CALC);
      done = (state == CALC) && (iterCount == CNT_W'(ITERATIONS - 1));
      root = rootNext;
      rem  = remNext[16:0];
   end

endmodule

// File: rtl/xif_sqrt_csr.sv
// -----------------------------------------------------------------------------
// xif_sqrt_csr
// Bus-attached square-root peripheral. Software writes a radicand to X, the
// block computes floor(sqrt(X)) over 16 cycles, then publishes ROOT and REM,
// sets DONE and optionally raises a level interrupt.
// Register window (BASE_ADDR-relative):
//   +0x0 X      rw   radicand
//   +0x4 STATUS      bit0 BUSY ro, bit1 DONE w1c, bit2 ERR w1c, bit8 IE rw
//   +0x8 ROOT   ro   [15:0]
//   +0xC REM    ro   [16:0]
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   xif_req_i     : request, always accepted the same cycle (xif_ack_o)
//   xif_we_i      : 1 write, 0 read
//   xif_addr_bi   : byte address
//   xif_be_bi     : write byte enables
//   xif_wdata_bi  : write data
//   xif_ack_o     : acceptance, mirrors xif_req_i
//   xif_resp_o    : read response valid, one cycle after the read
//   xif_rdata_bo  : read data, zero when xif_resp_o is low
//   irq_o         : registered DONE & IE
// -----------------------------------------------------------------------------
module xif_sqrt_csr
   import xif_sqrt_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h80000100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        xif_req_i,
   input  logic        xif_we_i,
   input  logic [31:0] xif_addr_bi,
   input  logic [3:0]  xif_be_bi,
   input  logic [31:0] xif_wdata_bi,
   output logic        xif_ack_o,
   output logic        xif_resp_o,
   output logic [31:0] xif_rdata_bo,
   output logic        irq_o
);

   logic [31:0] xReg;
   logic [15:0] rootReg;
   logic [16:0] remReg;
   logic        doneFlag;
   logic        errFlag;
   logic        ieFlag;
   logic        respValid;
   logic [31:0] rdataReg;
   logic        irqReg;

   logic        regHit;
   logic        rdHit;
   logic        wrX;
   logic        wrStatus;
   logic        startCalc;
   logic        errSet;
   logic        errClr;
   logic        doneClr;
   logic        ieWrite;
   logic [31:0] xMerged;
   logic [31:0] statusVal;
   logic [31:0] readVal;
   logic        doneNext;
   logic        errNext;
   logic        ieNext;

   logic        iterBusy;
   logic        iterDone;
   logic [15:0] iterRoot;
   logic [16:0] iterRem;

   assign xif_ack_o    = xif_req_i;
   assign xif_resp_o   = respValid;
   assign xif_rdata_bo = rdataReg;
   assign irq_o        = irqReg;

   sqrt_iter u_iter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start    (startCalc),
      .radicand (xMerged),
      .busy     (iterBusy),
      .done     (iterDone),
      .root     (iterRoot),
      .rem      (iterRem)
   );

   // Address decode. Only the four word offsets inside the window respond;
   // anything else, including unaligned offsets, is accepted but ignored.
   // A write to X with no byte enabled is treated as no write at all.
   // Writing X while a computation runs is refused and flagged via ERR.
   always_comb begin
      regHit = xif_req_i && (xif_addr_bi[31:4] == BASE_ADDR[31:4]) &&
               ((xif_addr_bi[3:0] == OFF_X)    || (xif_addr_bi[3:0] == OFF_STATUS) ||
                (xif_addr_bi[3:0] == OFF_ROOT) || (xif_addr_bi[3:0] == OFF_REM));
      rdHit     = regHit && !xif_we_i;
      wrX       = regHit && xif_we_i && (xif_addr_bi[3:0] == OFF_X) && (xif_be_bi != 4'h0);
      wrStatus  = regHit && xif_we_i && (xif_addr_bi[3:0] == OFF_STATUS);
      startCalc = wrX && !iterBusy;
      errSet    = wrX && iterBusy;
      doneClr   = wrStatus && xif_be_bi[0] && xif_wdata_bi[BIT_DONE];
      errClr    = wrStatus && xif_be_bi[0] && xif_wdata_bi[BIT_ERR];
      ieWrite   = wrStatus && xif_be_bi[1];
   end

   // Byte-lane merge of the incoming write onto the current X. This merged
   // value is both the new X and the radicand handed to the iterator.
   always_comb begin
      xMerged = xReg;
      for (int b = 0; b < 4; b++) begin
         if (xif_be_bi[b]) begin
            xMerged[8*b +: 8] = xif_wdata_bi[8*b +: 8];
         end
      end
   end

   // Next values of the STATUS flags. Later assignments take priority, so
   // completion beats a same-cycle DONE clear and an ERR set beats a clear.
   // Starting a new computation clears DONE from the previous one.
   always_comb begin
      doneNext = doneFlag;
      if (doneClr)   doneNext = 1'b0;
      if (startCalc) doneNext = 1'b0;
      if (iterDone)  doneNext = 1'b1;
      errNext = errFlag;
      if (errClr) errNext = 1'b0;
      if (errSet) errNext = 1'b1;
      ieNext = ieFlag;
      if (ieWrite) ieNext = xif_wdata_bi[BIT_IE];
   end

   // Read mux for the register addressed this cycle.
   always_comb begin
      statusVal           = '0;
      statusVal[BIT_BUSY] = iterBusy;
      statusVal[BIT_DONE] = doneFlag;
      statusVal[BIT_ERR]  = errFlag;
      statusVal[BIT_IE]   = ieFlag;
      case (xif_addr_bi[3:0])
         OFF_X:      readVal = xReg;
         OFF_STATUS: readVal = statusVal;
         OFF_ROOT:   readVal = {16'h0000, rootReg};
         OFF_REM:    readVal = {15'h0000, remReg};
         default:    readVal = '0;
      endcase
   end

   // Register file, read response and interrupt. ROOT and REM change only on
   // completion, so software never sees a half-finished result. The
   // interrupt is built from the next flag values so it rises and falls on
   // the same edge as DONE.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         xReg      <= '0;
         rootReg   <= '0;
         remReg    <= '0;
         doneFlag  <= 1'b0;
         errFlag   <= 1'b0;
         ieFlag    <= 1'b0;
         respValid <= 1'b0;
         rdataReg  <= '0;
         irqReg    <= 1'b0;
      end else begin
         if (startCalc) begin
            xReg <= xMerged;
         end
         if (iterDone) begin
            rootReg <= iterRoot;
            remReg  <= iterRem;
         end
         doneFlag  <= doneNext;
         errFlag   <= errNext;
         ieFlag    <= ieNext;
         respValid <= rdHit;
         rdataReg  <= rdHit ? readVal : 32'h0;
         irqReg    <= doneNext && ieNext;
      end
   end

endmodule

// File: tb/tb_xif_sqrt_csr.sv
// -----------------------------------------------------------------------------
// tb_xif_sqrt_csr
// Directed bench for the square-root peripheral. Each scenario task drives
// bus traffic and compares read-back values against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_xif_sqrt_csr;

   localparam logic [31:0] BASE   = 32'h80000100;
   localparam logic [31:0] A_X    = BASE + 32'h0;
   localparam logic [31:0] A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_ROOT = BASE + 32'h8;
   localparam logic [31:0] A_REM  = BASE + 32'hC;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        xif_req_i;
   logic        xif_we_i;
   logic [31:0] xif_addr_bi;
   logic [3:0]  xif_be_bi;
   logic [31:0] xif_wdata_bi;
   logic        xif_ack_o;
   logic        xif_resp_o;
   logic [31:0] xif_rdata_bo;
   logic        irq_o;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rd;
   logic        rsp;

   xif_sqrt_csr #(.BASE_ADDR(BASE)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .xif_req_i    (xif_req_i),
      .xif_we_i     (xif_we_i),
      .xif_addr_bi  (xif_addr_bi),
      .xif_be_bi    (xif_be_bi),
      .xif_wdata_bi (xif_wdata_bi),
      .xif_ack_o    (xif_ack_o),
      .xif_resp_o   (xif_resp_o),
      .xif_rdata_bo (xif_rdata_bo),
      .irq_o        (irq_o)
   );

   // 100 MHz free-running clock
   always #5 clk_i = ~clk_i;

   // One bus cycle: drive on the falling edge, let the rising edge accept it,
   // and return 1 ns into the following cycle with the bus released.
   task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata);
      @(negedge clk_i);
      xif_req_i    = 1'b1;
      xif_we_i     = we;
      xif_addr_bi  = addr;
      xif_be_bi    = be;
      xif_wdata_bi = wdata;
      @(posedge clk_i);
      #1;
      xif_req_i    = 1'b0;
      xif_we_i     = 1'b0;
      xif_addr_bi  = '0;
      xif_be_bi    = '0;
      xif_wdata_bi = '0;
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
      applyStimulus(1'b1, addr, be, wdata);
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data, output logic resp);
      applyStimulus(1'b0, addr, 4'h0, 32'h0);
      data = xif_rdata_bo;
      resp = xif_resp_o;
   endtask

   task automatic advance(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Bounded poll for completion; a timeout counts as a failed comparison.
   task automatic waitDone(input string tag);
      logic [31:0] s;
      logic        r;
      bit          seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         busRead(A_STAT, s, r);
         if (r && s[1] && !s[0]) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("[TB] FAIL %s_timeout: DONE not seen, last STATUS %h, want DONE=1 BUSY=0", tag, s);
      end
   endtask

   task automatic test_reset();
      logic [31:0] addrs [4];
      addrs = '{A_X, A_STAT, A_ROOT, A_REM};
      rst_i = 1'b1;
      advance(3);
      rst_i = 1'b0;
      checks++;
      if (irq_o !== 1'b0 || xif_resp_o !== 1'b0 || xif_rdata_bo !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: irq %b resp %b rdata %h, want 0 0 0", irq_o, xif_resp_o, xif_rdata_bo);
      end
      for (int i = 0; i < 4; i++) begin
         busRead(addrs[i], rd, rsp);
         checks++;
         if (rd !== 32'h0 || rsp !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_reg%0d: got %h resp %b, want 00000000 resp 1", i, rd, rsp);
         end
      end
      advance(1);
      checks++;
      if (xif_resp_o !== 1'b0 || xif_rdata_bo !== 32'h0) begin
         failures++;
         $display("[TB] FAIL resp_one_cycle: resp %b rdata %h, want 0 00000000", xif_resp_o, xif_rdata_bo);
      end
   endtask

   task automatic test_basic_144();
      busWrite(A_STAT, 4'b0010, 32'h0000_0100);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h100) begin
         failures++;
         $display("[TB] FAIL ie_set: got %h, want 00000100", rd);
      end
      busWrite(A_X, 4'hF, 32'd144);
      for (int k = 1; k <= 16; k++) begin
         busRead(A_STAT, rd, rsp);
         checks++;
         if (rd !== 32'h101 || rsp !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy_t%0d: got %h resp %b, want 00000101", k, rd, rsp);
         end
      end
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h102) begin
         failures++;
         $display("[TB] FAIL done_t17: got %h, want 00000102", rd);
      end
      checks++;
      if (irq_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL irq_144: got %b, want 1", irq_o);
      end
      busRead(A_ROOT, rd, rsp);
      checks++;
      if (rd !== 32'd12) begin
         failures++;
         $display("[TB] FAIL root_144: got %0d, want 12", rd);
      end
      busRead(A_REM, rd, rsp);
      checks++;
      if (rd !== 32'd0) begin
         failures++;
         $display("[TB] FAIL rem_144: got %0d, want 0", rd);
      end
      busRead(A_X, rd, rsp);
      checks++;
      if (rd !== 32'd144) begin
         failures++;
         $display("[TB] FAIL x_144: got %0d, want 144", rd);
      end
   endtask

   task automatic test_values();
      logic [31:0] xs    [5];
      logic [31:0] roots [5];
      logic [31:0] rems  [5];
      xs    = '{32'd0, 32'd2, 32'hFFFF_FFFF, 32'd1000000, 32'd99};
      roots = '{32'd0, 32'd1, 32'd65535,     32'd1000,    32'd9};
      rems  = '{32'd0, 32'd1, 32'd131070,    32'd0,       32'd18};
      for (int i = 0; i < 5; i++) begin
         busWrite(A_X, 4'hF, xs[i]);
         waitDone("values");
         busRead(A_ROOT, rd, rsp);
         checks++;
         if (rd !== roots[i]) begin
            failures++;
            $display("[TB] FAIL root_x%h: got %h, want %h", xs[i], rd, roots[i]);
         end
         busRead(A_REM, rd, rsp);
         checks++;
         if (rd !== rems[i]) begin
            failures++;
            $display("[TB] FAIL rem_x%h: got %h, want %h", xs[i], rd, rems[i]);
         end
      end
   endtask

   task automatic test_byte_enables();
      busWrite(A_X, 4'hF, 32'h1122_3344);
      waitDone("be_full");
      busWrite(A_X, 4'b0100, 32'hAABB_CCDD);
      waitDone("be_lane2");
      busRead(A_X, rd, rsp);
      checks++;
      if (rd !== 32'h11BB_3344) begin
         failures++;
         $display("[TB] FAIL x_byte_lane: got %h, want 11bb3344", rd);
      end
      busWrite(A_STAT, 4'b0001, 32'h0000_0100);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h102) begin
         failures++;
         $display("[TB] FAIL ie_masked: got %h, want 00000102", rd);
      end
      busWrite(A_STAT, 4'b0010, 32'h0000_0000);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h002 || irq_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ie_clear: got %h irq %b, want 00000002 irq 0", rd, irq_o);
      end
      busWrite(A_STAT, 4'b0010, 32'h0000_0100);
      checks++;
      if (irq_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ie_reenable_irq: got %b, want 1", irq_o);
      end
   endtask

   task automatic test_err();
      busWrite(A_X, 4'hF, 32'd144);
      advance(4);
      busWrite(A_X, 4'hF, 32'd9);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h105) begin
         failures++;
         $display("[TB] FAIL err_set: got %h, want 00000105", rd);
      end
      busRead(A_X, rd, rsp);
      checks++;
      if (rd !== 32'd144) begin
         failures++;
         $display("[TB] FAIL x_kept: got %0d, want 144", rd);
      end
      advance(9);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h106) begin
         failures++;
         $display("[TB] FAIL err_done_t17: got %h, want 00000106", rd);
      end
      busRead(A_ROOT, rd, rsp);
      checks++;
      if (rd !== 32'd12) begin
         failures++;
         $display("[TB] FAIL root_after_err: got %0d, want 12", rd);
      end
      busWrite(A_STAT, 4'b0001, 32'h0000_0004);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h102) begin
         failures++;
         $display("[TB] FAIL err_clear: got %h, want 00000102", rd);
      end
   endtask

   task automatic test_done_clear_race();
      busWrite(A_X, 4'hF, 32'd144);
      advance(15);
      busWrite(A_STAT, 4'b0001, 32'h0000_0002);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h102 || irq_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL done_race: got %h irq %b, want 00000102 irq 1", rd, irq_o);
      end
      busWrite(A_STAT, 4'b0001, 32'h0000_0002);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h100 || irq_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_clear: got %h irq %b, want 00000100 irq 0", rd, irq_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] addrs [4];
      addrs = '{A_X, A_STAT, A_ROOT, A_REM};
      busWrite(A_X, 4'hF, 32'd144);
      busRead(A_ROOT, rd, rsp);
      checks++;
      if (rd !== 32'd12) begin
         failures++;
         $display("[TB] FAIL root_held_mid: got %0d, want 12", rd);
      end
      advance(6);
      @(negedge clk_i);
      rst_i        = 1'b1;
      xif_req_i    = 1'b1;
      xif_we_i     = 1'b1;
      xif_addr_bi  = A_X;
      xif_be_bi    = 4'hF;
      xif_wdata_bi = 32'd5;
      #1;
      checks++;
      if (xif_ack_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ack_in_reset: got %b, want 1", xif_ack_o);
      end
      @(posedge clk_i);
      #1;
      rst_i        = 1'b0;
      xif_req_i    = 1'b0;
      xif_we_i     = 1'b0;
      xif_addr_bi  = '0;
      xif_be_bi    = '0;
      xif_wdata_bi = '0;
      for (int i = 0; i < 4; i++) begin
         busRead(addrs[i], rd, rsp);
         checks++;
         if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midreset_reg%0d: got %h, want 00000000", i, rd);
         end
      end
      advance(20);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h0 || irq_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL no_done_after_reset: got %h irq %b, want 00000000 irq 0", rd, irq_o);
      end
      busWrite(A_X, 4'hF, 32'd81);
      waitDone("x81");
      busRead(A_ROOT, rd, rsp);
      checks++;
      if (rd !== 32'd9) begin
         failures++;
         $display("[TB] FAIL root_81: got %0d, want 9", rd);
      end
      busRead(A_REM, rd, rsp);
      checks++;
      if (rd !== 32'd0 || irq_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rem_81: got %0d irq %b, want 0 irq 0", rd, irq_o);
      end
   endtask

   task automatic test_out_of_window();
      logic [31:0] badAddrs [3];
      badAddrs = '{BASE + 32'h10, BASE + 32'h2, 32'h0000_0100};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         xif_req_i   = 1'b1;
         xif_we_i    = 1'b0;
         xif_addr_bi = badAddrs[i];
         #1;
         checks++;
         if (xif_ack_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL oow_ack_%h: got %b, want 1", badAddrs[i], xif_ack_o);
         end
         @(posedge clk_i);
         #1;
         xif_req_i   = 1'b0;
         xif_addr_bi = '0;
         checks++;
         if (xif_resp_o !== 1'b0 || xif_rdata_bo !== 32'h0) begin
            failures++;
            $display("[TB] FAIL oow_resp_%h: resp %b rdata %h, want 0 00000000",
                     badAddrs[i], xif_resp_o, xif_rdata_bo);
         end
      end
      busWrite(BASE + 32'h10, 4'hF, 32'h0000_1234);
      busRead(A_STAT, rd, rsp);
      checks++;
      if (rd !== 32'h002) begin
         failures++;
         $display("[TB] FAIL oow_write_status: got %h, want 00000002", rd);
      end
      busRead(A_X, rd, rsp);
      checks++;
      if (rd !== 32'd81) begin
         failures++;
         $display("[TB] FAIL oow_write_x: got %0d, want 81", rd);
      end
   endtask

   // Scenario sequence; each task leaves the block in a known state for the
   // next one.
   initial begin
      rst_i        = 1'b1;
      xif_req_i    = 1'b0;
      xif_we_i     = 1'b0;
      xif_addr_bi  = '0;
      xif_be_bi    = '0;
      xif_wdata_bi = '0;
      $display("[TB] start");
      test_reset();
      test_basic_144();
      test_values();
      test_byte_enables();
      test_err();
      test_done_clear_race();
      test_reset_mid();
      test_out_of_window();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
